// File: rtl/fir_sched_pkg.sv
// Shared types and default widths for the FIR tap-chain sequencer.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fir_state_t;

    localparam int NTAPS_DEF = 8;
    localparam int IW_DEF    = 16;
    localparam int TW_DEF    = IW_DEF;
    localparam int OW_DEF    = IW_DEF + TW_DEF + 8;

    // Number of zero pulses needed to push every live sample out of the chain.
    function automatic int fill_count(input int ntaps);
        return ntaps + 1;
    endfunction

endpackage

// File: rtl/fir_sched_if.sv
// Valid/ready stream used for both the sample input and the result output.
interface fir_sched_if
    import fir_pkg::*;
#(
    parameter int W = IW_DEF
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/fir_sched_obuf.sv
// Two-entry valid/ready result FIFO with occupancy output.
module fir_obuf
    import fir_pkg::*;
#(
    parameter int W = OW_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready,
    output logic [1:0]   o_occ
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = o_valid & i_ready;
    // A push into a full buffer is legal only when the head leaves this cycle.
    assign do_push = i_valid & ((cnt != 2'd2) | do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign o_valid = (cnt != 2'd0);
    assign o_data  = mem[rd_ptr];
    assign o_occ   = cnt;

endmodule

// File: rtl/fir_sched.sv
// Sequencer for the systolic FIR tap chain: sample intake, ce pulses, result buffering, tap writes.
// Optional FIR_SCHED_WARMUP_EN drops the partial sums of the first NTAPS pulses after start.
module fir_sched
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int IW    = IW_DEF,
    parameter int TW    = IW,
    parameter int OW    = IW + TW + 8,
    parameter int AW    = $clog2(NTAPS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,

    input  logic          i_cfg_we,
    input  logic [AW-1:0] i_cfg_addr,
    input  logic [TW-1:0] i_cfg_data,
    output logic          o_cfg_err,

    input  logic          i_start,
    input  logic          i_flush,

    fir_sched_if.slave    s_if,

    output logic          o_fir_ce,
    output logic [IW-1:0] o_fir_sample,
    output logic          o_tap_we,
    output logic [AW-1:0] o_tap_addr,
    output logic [TW-1:0] o_tap_data,
    input  logic [OW-1:0] i_fir_acc,

    fir_sched_if.master   m_if,

    output logic          o_busy
);

    localparam int CW = $clog2(NTAPS + 2);
    localparam logic [CW-1:0] FILL_C = CW'(fill_count(NTAPS));
`ifdef FIR_SCHED_WARMUP_EN
    localparam logic [CW-1:0] WARM_C = CW'(NTAPS);
`endif

    fir_state_t    state, state_nxt;
    logic [CW-1:0] fill_cnt;
    logic [CW-1:0] flush_cnt;
    logic          cap_pend;
    logic          cap_keep;
    logic          keep_now;
    logic [1:0]    occ;
    logic          pop;
    logic          credit;

    assign pop = m_if.valid & m_if.ready;
    // A slot freed by this cycle's pop is usable now, sustaining one sample per cycle.
    assign credit = ((({1'b0, occ}) + {2'b00, cap_pend}) < 3'd2) | pop;

`ifdef FIR_SCHED_WARMUP_EN
    assign keep_now = (fill_cnt >= WARM_C);
`else
    assign keep_now = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        o_fir_ce     = 1'b0;
        o_fir_sample = '0;
        s_if.ready   = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                s_if.ready   = credit;
                o_fir_sample = s_if.data;
                o_fir_ce     = s_if.valid & credit;
                if (i_flush) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                o_fir_ce = credit & (flush_cnt < FILL_C);
                // Leave only once the final zero pulse's capture has landed.
                if ((flush_cnt == FILL_C) && cap_pend) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cap_pend  <= 1'b0;
            cap_keep  <= 1'b0;
            fill_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            cap_pend <= o_fir_ce;
            cap_keep <= keep_now;
            if ((state == IDLE) && i_start) begin
                fill_cnt <= '0;
            end else if (o_fir_ce && (fill_cnt != FILL_C)) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (state == RUN) begin
                flush_cnt <= '0;
            end else if ((state == FLUSH) && o_fir_ce) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tap_we   <= 1'b0;
            o_tap_addr <= '0;
            o_tap_data <= '0;
            o_cfg_err  <= 1'b0;
        end else begin
            o_tap_we  <= i_cfg_we && (state == IDLE);
            o_cfg_err <= i_cfg_we && (state != IDLE);
            if (i_cfg_we && (state == IDLE)) begin
                o_tap_addr <= i_cfg_addr;
                o_tap_data <= i_cfg_data;
            end
        end
    end

    fir_obuf #(
        .W (OW)
    ) u_obuf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (cap_pend & cap_keep),
        .i_data  (i_fir_acc),
        .o_valid (m_if.valid),
        .o_data  (m_if.data),
        .i_ready (m_if.ready),
        .o_occ   (occ)
    );

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_fir_sched.sv
// Directed self-checking bench for fir_sched with a counting tap-chain stand-in.
module tb_fir_sched;

`ifdef FIR_SCHED_WARMUP_EN
    localparam int WARM = 8;
`else
    localparam int WARM = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_err;
    logic        start;
    logic        flush;
    logic        fir_ce;
    logic [15:0] fir_sample;
    logic        tap_we;
    logic [2:0]  tap_addr;
    logic [15:0] tap_data;
    logic [39:0] fir_acc = '0;
    logic        busy;

    int passed = 0;
    int total  = 0;

    fir_sched_if #(.W(16)) s_if ();
    fir_sched_if #(.W(40)) m_if ();

    fir_sched #(
        .NTAPS (8),
        .IW    (16)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cfg_we     (cfg_we),
        .i_cfg_addr   (cfg_addr),
        .i_cfg_data   (cfg_data),
        .o_cfg_err    (cfg_err),
        .i_start      (start),
        .i_flush      (flush),
        .s_if         (s_if),
        .o_fir_ce     (fir_ce),
        .o_fir_sample (fir_sample),
        .o_tap_we     (tap_we),
        .o_tap_addr   (tap_addr),
        .o_tap_data   (tap_data),
        .i_fir_acc    (fir_acc),
        .m_if         (m_if),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Chain stand-in: accumulator reports {global ce number, sample of that ce}.
    int chain_cnt = 0;
    always @(posedge clk) begin
        if (fir_ce) begin
            chain_cnt <= chain_cnt + 1;
            fir_acc   <= {24'(chain_cnt + 1), fir_sample};
        end
    end

    int          ce_cyc[$];
    logic [15:0] ce_smp[$];
    logic [39:0] got[$];
    int          got_cyc[$];
    always @(negedge clk) begin
        #2;
        if (fir_ce) begin
            ce_cyc.push_back(cyc);
            ce_smp.push_back(fir_sample);
        end
        if (m_if.valid && m_if.ready) begin
            got.push_back(m_if.data);
            got_cyc.push_back(cyc);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; s_if.valid = 1'b0; m_if.ready = 1'b1;
        start = 1'b0; flush = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ce_cyc.delete(); ce_smp.delete(); got.delete(); got_cyc.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_if.valid = 1'b1; s_if.data = 16'h5A5A; m_if.ready = 1'b1;
        start = 1'b0; flush = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (2) @(negedge clk);
        #1;
        if (fir_ce !== 1'b0) $display("FAIL rst_ce: got %b want 0", fir_ce); else passed++; total++;
        if (s_if.ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", s_if.ready); else passed++; total++;
        if (m_if.valid !== 1'b0) $display("FAIL rst_m_valid: got %b want 0", m_if.valid); else passed++; total++;
        if (m_if.data !== 40'h0) $display("FAIL rst_m_data: got %h want 0", m_if.data); else passed++; total++;
        if (tap_we !== 1'b0) $display("FAIL rst_tap_we: got %b want 0", tap_we); else passed++; total++;
        if (tap_addr !== 3'd0) $display("FAIL rst_tap_addr: got %h want 0", tap_addr); else passed++; total++;
        if (tap_data !== 16'h0) $display("FAIL rst_tap_data: got %h want 0", tap_data); else passed++; total++;
        if (cfg_err !== 1'b0) $display("FAIL rst_cfg_err: got %b want 0", cfg_err); else passed++; total++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++; total++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        if (s_if.ready !== 1'b0) $display("FAIL idle_s_ready: got %b want 0", s_if.ready); else passed++; total++;
        if (fir_ce !== 1'b0) $display("FAIL idle_ce: got %b want 0", fir_ce); else passed++; total++;
        s_if.valid = 1'b0;
    endtask

    task automatic test_cfg();
        do_reset();
        @(negedge clk); cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 16'h1234;
        @(negedge clk); cfg_we = 1'b0; #1;
        if (tap_we !== 1'b1) $display("FAIL cfg_tap_we: got %b want 1", tap_we); else passed++; total++;
        if (tap_addr !== 3'd3) $display("FAIL cfg_tap_addr: got %h want 3", tap_addr); else passed++; total++;
        if (tap_data !== 16'h1234) $display("FAIL cfg_tap_data: got %h want 1234", tap_data); else passed++; total++;
        if (cfg_err !== 1'b0) $display("FAIL cfg_err_idle: got %b want 0", cfg_err); else passed++; total++;
        @(negedge clk); #1;
        if (tap_we !== 1'b0) $display("FAIL cfg_tap_we_pulse: got %b want 0", tap_we); else passed++; total++;
        // start + flush + write together in IDLE: write lands, RUN entered
        @(negedge clk); start = 1'b1; flush = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd5; cfg_data = 16'hBEEF;
        @(negedge clk); start = 1'b0; flush = 1'b0; cfg_we = 1'b0; #1;
        if (tap_we !== 1'b1) $display("FAIL start_wr_tap_we: got %b want 1", tap_we); else passed++; total++;
        if (tap_addr !== 3'd5) $display("FAIL start_wr_addr: got %h want 5", tap_addr); else passed++; total++;
        if (busy !== 1'b1) $display("FAIL start_busy: got %b want 1", busy); else passed++; total++;
        if (s_if.ready !== 1'b1) $display("FAIL start_wins_ready: got %b want 1", s_if.ready); else passed++; total++;
        @(negedge clk); cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 16'h5555;
        @(negedge clk); cfg_we = 1'b0; #1;
        if (cfg_err !== 1'b1) $display("FAIL run_cfg_err: got %b want 1", cfg_err); else passed++; total++;
        if (tap_we !== 1'b0) $display("FAIL run_tap_we: got %b want 0", tap_we); else passed++; total++;
        if (tap_data !== 16'hBEEF) $display("FAIL run_tap_data: got %h want beef", tap_data); else passed++; total++;
        @(negedge clk); #1;
        if (cfg_err !== 1'b0) $display("FAIL run_cfg_err_pulse: got %b want 0", cfg_err); else passed++; total++;
    endtask

    task automatic test_stream();
        int sent;
        int base;
        int bad;
        do_reset();
        base = chain_cnt;
        pulse_start();
        sent = 0;
        for (int c = 0; c < 60 && sent < 20; c++) begin
            @(negedge clk); s_if.valid = 1'b1; s_if.data = 16'(16'hA000 + sent); #1;
            if (fir_ce) sent++;
        end
        @(negedge clk); s_if.valid = 1'b0;
        repeat (6) @(negedge clk);
        #3;
        if (sent !== 20) $display("FAIL stream_sent: got %0d want 20", sent); else passed++; total++;
        if (ce_cyc.size() != 20 || ce_cyc[19] - ce_cyc[0] !== 19)
            $display("FAIL stream_rate: got %0d ce spanning %0d cycles want 20 over 19", ce_cyc.size(),
                     ce_cyc.size() ? ce_cyc[ce_cyc.size()-1] - ce_cyc[0] : -1);
        else passed++;
        total++;
        if (got.size() !== 20 - WARM) $display("FAIL stream_count: got %0d want %0d", got.size(), 20 - WARM); else passed++; total++;
        if (got.size() == 0 || ce_cyc.size() <= WARM || got_cyc[0] - ce_cyc[WARM] !== 2)
            $display("FAIL stream_latency: got %0d want 2",
                     (got.size() && ce_cyc.size() > WARM) ? got_cyc[0] - ce_cyc[WARM] : -1);
        else passed++;
        total++;
        bad = 0;
        for (int k = 0; k < got.size() && k < 20 - WARM; k++) begin
            if (got[k] !== {24'(base + WARM + k + 1), 16'(16'hA000 + WARM + k)}) bad++;
        end
        if (bad !== 0 || got.size() == 0) $display("FAIL stream_data: got %0d bad words want 0", bad); else passed++; total++;
    endtask

    task automatic test_backpressure();
        int sent;
        int base;
        int bad;
        do_reset();
        base = chain_cnt;
        pulse_start();
        m_if.ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk); s_if.valid = 1'b1; s_if.data = 16'(16'hB000 + sent); #1;
            if (fir_ce) sent++;
        end
        if (sent !== WARM + 2) $display("FAIL bp_ce_count: got %0d want %0d", sent, WARM + 2); else passed++; total++;
        if (s_if.ready !== 1'b0) $display("FAIL bp_s_ready: got %b want 0", s_if.ready); else passed++; total++;
        if (m_if.valid !== 1'b1) $display("FAIL bp_m_valid: got %b want 1", m_if.valid); else passed++; total++;
        for (int c = 0; c < 80 && sent < 14; c++) begin
            @(negedge clk); m_if.ready = 1'b1; s_if.valid = 1'b1; s_if.data = 16'(16'hB000 + sent); #1;
            if (fir_ce) sent++;
        end
        @(negedge clk); s_if.valid = 1'b0;
        repeat (6) @(negedge clk);
        #3;
        if (got.size() !== 14 - WARM) $display("FAIL bp_count: got %0d want %0d", got.size(), 14 - WARM); else passed++; total++;
        bad = 0;
        for (int k = 0; k < got.size() && k < 14 - WARM; k++) begin
            if (got[k] !== {24'(base + WARM + k + 1), 16'(16'hB000 + WARM + k)}) bad++;
        end
        if (bad !== 0 || got.size() == 0) $display("FAIL bp_data: got %0d bad words want 0", bad); else passed++; total++;
    endtask

    task automatic test_flush();
        int sent;
        int base;
        int n0;
        int nz;
        int rdy;
        int done_cyc;
        do_reset();
        base = chain_cnt;
        pulse_start();
        sent = 0;
        for (int c = 0; c < 20 && sent < 3; c++) begin
            @(negedge clk); s_if.valid = 1'b1; s_if.data = 16'(16'hC000 + sent); #1;
            if (fir_ce) sent++;
        end
        @(negedge clk); s_if.valid = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0; s_if.valid = 1'b1; s_if.data = 16'hFFFF;
        n0 = ce_cyc.size();
        nz = 0; rdy = 0; done_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!busy) begin
                done_cyc = cyc;
                break;
            end
            if (s_if.ready) rdy++;
            if (fir_ce && fir_sample != 16'h0) nz++;
            @(negedge clk);
        end
        s_if.valid = 1'b0;
        #2;
        if (ce_cyc.size() - n0 !== 9) $display("FAIL flush_ce_count: got %0d want 9", ce_cyc.size() - n0); else passed++; total++;
        if (nz !== 0) $display("FAIL flush_sample: got %0d nonzero want 0", nz); else passed++; total++;
        if (rdy !== 0) $display("FAIL flush_s_ready: got %0d ready cycles want 0", rdy); else passed++; total++;
        if (done_cyc < 0 || ce_cyc.size() == 0 || done_cyc - ce_cyc[ce_cyc.size()-1] !== 2)
            $display("FAIL flush_idle: got %0d cycles after last ce want 2",
                     (done_cyc < 0 || ce_cyc.size() == 0) ? -1 : done_cyc - ce_cyc[ce_cyc.size()-1]);
        else passed++;
        total++;
        repeat (4) @(negedge clk);
        #3;
        if (got.size() !== 12 - WARM) $display("FAIL flush_results: got %0d want %0d", got.size(), 12 - WARM); else passed++; total++;
        if (got.size() == 0 || got[got.size()-1] !== {24'(base + 12), 16'h0})
            $display("FAIL flush_last: got %h want %h", got.size() ? got[got.size()-1] : 40'h0, {24'(base + 12), 16'h0});
        else passed++;
        total++;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        pulse_start();
        m_if.ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk); s_if.valid = 1'b1; s_if.data = 16'(16'hD000 + c);
        end
        #1;
        if (m_if.valid !== 1'b1) $display("FAIL mid_m_valid_pre: got %b want 1", m_if.valid); else passed++; total++;
        @(negedge clk); rst_n = 1'b0; s_if.valid = 1'b0; #1;
        if (m_if.valid !== 1'b0) $display("FAIL mid_m_valid: got %b want 0", m_if.valid); else passed++; total++;
        if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else passed++; total++;
        if (m_if.data !== 40'h0) $display("FAIL mid_m_data: got %h want 0", m_if.data); else passed++; total++;
        @(negedge clk); rst_n = 1'b1; m_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        if (got.size() !== 0) $display("FAIL mid_lost: got %0d results want 0", got.size()); else passed++; total++;
    endtask

    initial begin
        test_reset();
        test_cfg();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_midrun();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fir_sched.md
# fir_sched

Sequencer for the systolic FIR tap chain in the accelerator datapath. Accepts input samples over a valid/ready stream, issues single-cycle clock-enable pulses to the tap chain, captures the chain's accumulator output into a 2-entry output buffer with downstream backpressure, and owns the tap-coefficient write port. Sits between the peripheral bus register block and the tap chain.

## Interface
- NTAPS, 8, number of taps in the chain
- IW, 16, sample width
- TW, IW, tap width
- OW, IW+TW+8, accumulator width
- AW, $clog2(NTAPS), tap address width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_cfg_we / i_cfg_addr / i_cfg_data  in  1/AW/TW  coefficient write request
- o_cfg_err  out  1  one-cycle pulse: write rejected
- i_start  in  1  pulse: begin streaming
- i_flush  in  1  pulse: drain chain with zeros, then idle
- i_s_valid / i_s_data  in  1/IW  input sample stream; o_s_ready  out  1
- o_fir_ce  out  1  tap-chain clock enable
- o_fir_sample  out  IW  sample to tap chain (valid with o_fir_ce)
- o_tap_we / o_tap_addr / o_tap_data  out  1/AW/TW  tap register write
- i_fir_acc  in  OW  final accumulator of the chain
- o_m_valid / o_m_data  out  1/OW  result stream; i_m_ready  in  1
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, RUN, FLUSH. Reset -> IDLE.
- IDLE: i_cfg_we forwarded to o_tap_* one cycle later (registered). i_start -> RUN, fill counter cleared. i_flush ignored.
- RUN/FLUSH: i_cfg_we rejected, o_cfg_err pulses next cycle, no tap write.
- RUN: o_fir_ce asserted in cycle t when i_s_valid and credit available; o_s_ready = credit available; handshake and ce coincide; o_fir_sample = i_s_data registered-free (combinational pass-through). i_flush -> FLUSH.
- Credit: buffer occupancy + pending capture < 2.
- Capture: cycle t+1 after any ce, i_fir_acc written into buffer (subject to warm-up, see Configuration).
- FLUSH: issues NTAPS+1 ce pulses with sample 0, each gated by credit; i_s_valid ignored, o_s_ready = 0. After last pulse's capture enters buffer -> IDLE (buffer still drains).
- Fill counter: saturating count of ce pulses since start, width $clog2(NTAPS+2).
- Arithmetic: none on data; i_fir_acc passed unmodified at OW bits.

## Timing
- Reset values: o_fir_ce 0, o_s_ready 0, o_m_valid 0, o_m_data 0, o_tap_we 0, o_tap_addr 0, o_tap_data 0, o_cfg_err 0, o_busy 0.
- Sample to result: ce at t, result in buffer at t+1, o_m_valid at t+2 earliest.
- Sustained throughput 1 sample/cycle while i_m_ready held high.
- Buffer full (2 entries, none pending): o_s_ready 0 and no ce until a pop.
- Pop and push same cycle on full buffer: allowed, occupancy unchanged.
- i_start and i_cfg_we same cycle in IDLE: write performed and RUN entered.
- i_start and i_flush same cycle in IDLE: start wins.
- Reset mid-run: state, buffer, counters cleared immediately; queued results lost.

## Configuration
- FIR_SCHED_WARMUP_EN defined: captures of the first NTAPS ce pulses after i_start are discarded (no buffer push, credit still released); first delivered result corresponds to ce NTAPS+1.
- Undefined: every capture delivered, including warm-up partial sums.

## Structure
- fir_pkg: state enum (IDLE, RUN, FLUSH), default width localparams, FILL = NTAPS+1.
- Sub-module fir_obuf: 2-entry valid/ready FIFO with occupancy output, used for the result buffer.

## Test plan
- Reset with i_s_valid high -> all outputs at reset values; o_s_ready 0 until start.
- IDLE write addr 3 data 0x1234 -> o_tap_we 1, o_tap_addr 3, o_tap_data 0x1234 next cycle; same write in RUN -> o_cfg_err pulse, no o_tap_we.
- NTAPS=8, warm-up enabled, stream 20 samples, i_m_ready high -> 12 results, o_m_valid 2 cycles after 9th ce, one ce per cycle.
- i_m_ready low, stream samples -> exactly 2 ce pulses then o_s_ready 0; raise i_m_ready -> stream resumes, no result lost or duplicated.
- i_flush in RUN -> 9 ce pulses with o_fir_sample 0, o_s_ready 0, then IDLE and o_busy 0.
- Reset asserted with 2 results buffered -> o_m_valid 0 same cycle, state IDLE.
